poly_square_synth: RTL and testbench
====================================

Name: poly_square_synth

Overview:
- Polyphonic successor to the single-voice keyboard square-wave path: consumes the PS/2 scan-code stream (data byte + valid strobe), tracks make/break per key and allocates up to NUM_VOICES square-wave voices.
- Mixes the active voices into one signed sample with saturating volume control.
- Presents the sample to the audio codec interface with a periodic wr strobe.
- Sits between ps2_keyboard and the codec writer; replaces the single SquareCode/KeyToNote pair.

Parameters:
- NUM_VOICES, 4, simultaneous voices; power of two, 1..8.
- SAMPLE_DIV, 1042, clock cycles per output sample (50 MHz / 1042 ≈ 48 kHz).
- VOLUME_INIT, 16'h3FFF, volume after reset.
- VOLUME_STEP, 16'h0800, increment/decrement per volume pulse.
- VOLUME_MAX, 16'h7FFF, upper volume bound.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- data  in  8  PS/2 scan-code byte, valid only when valid_data=1.
- valid_data  in  1  single-cycle strobe per received byte.
- vol_up  in  1  single-cycle pulse, already synchronised and edge-detected.
- vol_down  in  1  single-cycle pulse, already synchronised and edge-detected.
- sample_out  out  16  signed two's-complement mixed sample, registered.
- wr  out  1  single-cycle strobe; sample_out changes only in the cycle wr=1.
- active_mask  out  NUM_VOICES  bit i=1 when voice i is sounding.
- last_note  out  8  scan code of the most recent accepted make, for the seven-segment display.

Behaviour:
- Reset: all voices free; phase counters 0; levels 0; volume=VOLUME_INIT; sample_out=0; wr=0; active_mask=0; last_note=8'h00; parser flags cleared. Reset mid-note silences the output immediately.
- Parser (evaluated on valid_data):
  - 8'hE0 sets ext_flag.
  - 8'hF0 sets brk_flag.
  - Any other byte is a key code. Both flags clear after a key code.
  - ext_flag=1: the code is ignored, whether make or break.
  - brk_flag=1: release. The voice holding that code is freed the next cycle and its level cleared; no match means no action.
  - Otherwise the byte is a make. Unmapped codes are ignored.
    - Code already held by a voice (typematic repeat): no change.
    - Else allocate the lowest-index free voice.
    - If none is free, steal the voice at steal_ptr and increment steal_ptr modulo NUM_VOICES.
    - Allocated voice: code stored, counter=0, level=1, active the next cycle. last_note is updated.
- Note table (audio_pkg; half period in clocks at 50 MHz):
  - Q 15→95556, W 1D→90194, E 24→85131, R 2D→80353
  - T 2C→75843, Y 35→71586, U 3C→67568, I 43→63776
  - O 44→60197, P 4D→56818, [ 54→53629, ] 5B→50619
- Voice:
  - 21-bit counter increments each clock while active.
  - At half_period-1 the counter wraps to 0 and level toggles.
  - An inactive voice contributes 0.
- Mix:
  - amp = volume >> log2(NUM_VOICES).
  - Sum over active voices of (+amp if level else −amp), accumulated at 19 bits, then saturated to [−32768, 32767]. Clamping never triggers for legal volume, but is required.
- Sample timing:
  - Divider counts 0..SAMPLE_DIV−1.
  - At terminal count: wr=1 for one cycle and sample_out takes the mix of the previous cycle's voice state.
  - Latency from a make byte to its first audible sample: at most SAMPLE_DIV+2 cycles.
- Volume:
  - vol_up adds VOLUME_STEP, saturating at VOLUME_MAX.
  - vol_down subtracts VOLUME_STEP, saturating at 0. No wrap-around.
  - vol_up and vol_down in the same cycle: no change.
- Make and break for the same code cannot share a cycle: one byte per strobe.

Decomposition:
- audio_pkg holds:
  - scan-code constants, BREAK_CODE=8'hF0, EXT_CODE=8'hE0.
  - the note-lookup function, returning {hit, half_period[20:0]}.
  - HALF_PERIOD_W=21.
- square_voice is the natural sub-module: counter, level and active bit, with alloc/release inputs. It is generated NUM_VOICES times.
- Parser, allocator, mixer and volume logic stay in poly_square_synth.

Test Plan:
- Reset then idle 5000 cycles -> sample_out=0, wr pulses every 1042 cycles, active_mask=0.
- Send 8'h15 -> active_mask=4'b0001, last_note=8'h15. Voice 0 level toggles every 95556 cycles. sample_out alternates +4095/−4095 (amp=16'h3FFF>>2).
- Send 15,1D,24,2D,2C (no breaks) -> fifth make steals voice 0. active_mask=4'b1111; voice 0 half period becomes 75843. steal_ptr=1.
- Send 15 then F0 15 -> active_mask returns to 0. Send E0 15 and E0 F0 15 -> no voice change.
- Repeat 8'h1D three times -> only voice 0 allocated; counter not restarted on repeats.
- Volume: 9 vol_up pulses from reset -> volume saturates at 16'h7FFF. Then 20 vol_down -> 0. Simultaneous vol_up+vol_down -> volume unchanged.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and the note lookup for the polyphonic square-wave synth.
package audio_pkg;

  localparam int HALF_PERIOD_W = 21;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam logic [7:0] KEY_Q    = 8'h15;
  localparam logic [7:0] KEY_W    = 8'h1D;
  localparam logic [7:0] KEY_E    = 8'h24;
  localparam logic [7:0] KEY_R    = 8'h2D;
  localparam logic [7:0] KEY_T    = 8'h2C;
  localparam logic [7:0] KEY_Y    = 8'h35;
  localparam logic [7:0] KEY_U    = 8'h3C;
  localparam logic [7:0] KEY_I    = 8'h43;
  localparam logic [7:0] KEY_O    = 8'h44;
  localparam logic [7:0] KEY_P    = 8'h4D;
  localparam logic [7:0] KEY_LBRK = 8'h54;
  localparam logic [7:0] KEY_RBRK = 8'h5B;

  // Returns {hit, half_period}; half period is in 50 MHz clocks.
  function automatic logic [HALF_PERIOD_W:0] note_lookup(input logic [7:0] code);
    logic [HALF_PERIOD_W:0] r;
    case (code)
      KEY_Q:    r = {1'b1, 21'd95556};
      KEY_W:    r = {1'b1, 21'd90194};
      KEY_E:    r = {1'b1, 21'd85131};
      KEY_R:    r = {1'b1, 21'd80353};
      KEY_T:    r = {1'b1, 21'd75843};
      KEY_Y:    r = {1'b1, 21'd71586};
      KEY_U:    r = {1'b1, 21'd67568};
      KEY_I:    r = {1'b1, 21'd63776};
      KEY_O:    r = {1'b1, 21'd60197};
      KEY_P:    r = {1'b1, 21'd56818};
      KEY_LBRK: r = {1'b1, 21'd53629};
      KEY_RBRK: r = {1'b1, 21'd50619};
      default:  r = {1'b0, 21'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/poly_square_synth_voice.sv
// One square-wave voice: half-period counter, output level and active bit.
module square_voice
  import audio_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alloc,
  input  logic                     rel,
  input  logic [7:0]               code_in,
  input  logic [HALF_PERIOD_W-1:0] hp_in,
  output logic                     active,
  output logic                     level,
  output logic [7:0]               code
);

  logic                     active_q, active_d;
  logic                     level_q, level_d;
  logic [HALF_PERIOD_W-1:0] cnt_q, cnt_d;
  logic [HALF_PERIOD_W-1:0] hp_q, hp_d;
  logic [7:0]               code_q, code_d;

  // Next state: allocation wins over release; an active voice counts and toggles at half_period-1.
  always_comb begin
    active_d = active_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    hp_d     = hp_q;
    code_d   = code_q;
    if (alloc) begin
      active_d = 1'b1;
      level_d  = 1'b1;
      cnt_d    = {HALF_PERIOD_W{1'b0}};
      hp_d     = hp_in;
      code_d   = code_in;
    end else if (rel) begin
      active_d = 1'b0;
      level_d  = 1'b0;
      cnt_d    = {HALF_PERIOD_W{1'b0}};
    end else if (active_q) begin
      if (cnt_q == hp_q - 21'd1) begin
        cnt_d   = {HALF_PERIOD_W{1'b0}};
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 21'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Voice state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      level_q  <= 1'b0;
      cnt_q    <= {HALF_PERIOD_W{1'b0}};
      hp_q     <= {HALF_PERIOD_W{1'b0}};
      code_q   <= 8'h00;
    end else begin
      active_q <= active_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      code_q   <= code_d;
    end
  end

  assign active = active_q;
  assign level  = level_q;
  assign code   = code_q;

endmodule

// File: rtl/poly_square_synth.sv
// Polyphonic square-wave synth: PS/2 parser, voice allocator, mixer, volume and sample pacing.
module poly_square_synth
  import audio_pkg::*;
#(
  parameter int          NUM_VOICES  = 4,
  parameter int          SAMPLE_DIV  = 1042,
  parameter logic [15:0] VOLUME_INIT = 16'h3FFF,
  parameter logic [15:0] VOLUME_STEP = 16'h0800,
  parameter logic [15:0] VOLUME_MAX  = 16'h7FFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            data,
  input  logic                  valid_data,
  input  logic                  vol_up,
  input  logic                  vol_down,
  output logic [15:0]           sample_out,
  output logic                  wr,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic [7:0]            last_note
);

  localparam int VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int AMP_SHIFT = $clog2(NUM_VOICES);
  localparam int DIV_W     = $clog2(SAMPLE_DIV);

  logic [NUM_VOICES-1:0] voice_active_s, voice_level_s, alloc_s, rel_s, match_s;
  logic [7:0]            voice_code_s [NUM_VOICES];

  logic                  ext_q, ext_d, brk_q, brk_d;
  logic [VIDX_W-1:0]     steal_ptr_q, steal_ptr_d;
  logic [7:0]            last_note_q, last_note_d;
  logic [15:0]           volume_q, volume_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  wr_q, wr_d;
  logic [15:0]           sample_q, sample_d;

  logic [HALF_PERIOD_W:0] lookup_s;
  logic                   free_found_s;
  logic [VIDX_W-1:0]      free_idx_s, target_s;
  logic [15:0]            amp_s;
  logic signed [18:0]     amp19_s, mix_s;
  logic [15:0]            sat_s;
  logic [16:0]            vol_sum_s;
  logic                   tc_s;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    square_voice u_voice (
      .clock   (clock),
      .reset   (reset),
      .alloc   (alloc_s[i]),
      .rel     (rel_s[i]),
      .code_in (data),
      .hp_in   (lookup_s[HALF_PERIOD_W-1:0]),
      .active  (voice_active_s[i]),
      .level   (voice_level_s[i]),
      .code    (voice_code_s[i])
    );
  end

  // Parser and allocator: prefix flags, release by code match, make to lowest free voice or steal.
  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    steal_ptr_d  = steal_ptr_q;
    last_note_d  = last_note_q;
    alloc_s      = '0;
    rel_s        = '0;
    lookup_s     = note_lookup(data);
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      match_s[i] = voice_active_s[i] && (voice_code_s[i] == data);
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      free_found_s = free_found_s | ~voice_active_s[i];
      free_idx_s   = voice_active_s[i] ? free_idx_s : VIDX_W'(i);
    end
    target_s = free_found_s ? free_idx_s : steal_ptr_q;
    if (valid_data) begin
      if (data == EXT_CODE) begin
        ext_d = 1'b1;
      end else if (data == BREAK_CODE) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (ext_q) begin
          rel_s = '0;
        end else if (brk_q) begin
          rel_s = match_s;
        end else if (lookup_s[HALF_PERIOD_W] && !(|match_s)) begin
          alloc_s[target_s] = 1'b1;
          last_note_d       = data;
          if (!free_found_s) begin
            steal_ptr_d = (steal_ptr_q == VIDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + VIDX_W'(1);
          end else begin
            steal_ptr_d = steal_ptr_q;
          end
        end else begin
          alloc_s = '0;
        end
      end
    end else begin
      alloc_s = '0;
    end
  end

  // Mixer: signed sum of +/-amp over active voices, clamped to 16-bit range.
  always_comb begin
    amp_s   = volume_q >> AMP_SHIFT;
    amp19_s = signed'({3'b000, amp_s});
    mix_s   = 19'sd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_s = mix_s + (voice_active_s[i] ? (voice_level_s[i] ? amp19_s : -amp19_s) : 19'sd0);
    end
    if (mix_s > 19'sd32767) begin
      sat_s = 16'h7FFF;
    end else if (mix_s < -19'sd32768) begin
      sat_s = 16'h8000;
    end else begin
      sat_s = mix_s[15:0];
    end
  end

  // Sample pacing and saturating volume control.
  always_comb begin
    tc_s      = (div_q == DIV_W'(SAMPLE_DIV - 1));
    div_d     = tc_s ? '0 : div_q + DIV_W'(1);
    wr_d      = tc_s;
    sample_d  = tc_s ? sat_s : sample_q;
    vol_sum_s = {1'b0, volume_q} + {1'b0, VOLUME_STEP};
    if (vol_up && !vol_down) begin
      volume_d = (vol_sum_s > {1'b0, VOLUME_MAX}) ? VOLUME_MAX : vol_sum_s[15:0];
    end else if (vol_down && !vol_up) begin
      volume_d = (volume_q < VOLUME_STEP) ? 16'h0000 : volume_q - VOLUME_STEP;
    end else begin
      volume_d = volume_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      steal_ptr_q <= '0;
      last_note_q <= 8'h00;
      volume_q    <= VOLUME_INIT;
      div_q       <= '0;
      wr_q        <= 1'b0;
      sample_q    <= 16'h0000;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      steal_ptr_q <= steal_ptr_d;
      last_note_q <= last_note_d;
      volume_q    <= volume_d;
      div_q       <= div_d;
      wr_q        <= wr_d;
      sample_q    <= sample_d;
    end
  end

  assign sample_out  = sample_q;
  assign wr          = wr_q;
  assign active_mask = voice_active_s;
  assign last_note   = last_note_q;

endmodule

// File: tb/tb_poly_square_synth.sv
// Directed bench for poly_square_synth with hand-computed expectations.
module tb_poly_square_synth;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  data;
  logic        valid_data, vol_up, vol_down;
  logic [15:0] sample_out;
  logic        wr;
  logic [3:0]  active_mask;
  logic [7:0]  last_note;

  int checks = 0;
  int passes = 0;
  int got;
  int cyc;
  logic [20:0] cnt_snap;

  poly_square_synth dut (
    .clock       (clock),
    .reset       (reset),
    .data        (data),
    .valid_data  (valid_data),
    .vol_up      (vol_up),
    .vol_down    (vol_down),
    .sample_out  (sample_out),
    .wr          (wr),
    .active_mask (active_mask),
    .last_note   (last_note)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data       = b;
    valid_data = 1'b1;
    tick();
    valid_data = 1'b0;
    data       = 8'h00;
    tick();
  endtask

  task automatic pulse_vol(input logic up, input logic dn);
    vol_up   = up;
    vol_down = dn;
    tick();
    vol_up   = 1'b0;
    vol_down = 1'b0;
  endtask

  task automatic wait_wr(input string tag);
    got = 0;
    for (int n = 0; n < 1100; n++) begin
      tick();
      if (wr) begin
        got = 1;
        break;
      end
    end
    check(tag, got, 1);
  endtask

  initial begin
    reset = 1'b1; data = 8'h00; valid_data = 1'b0; vol_up = 1'b0; vol_down = 1'b0;
    repeat (3) tick();
    check("rst_sample", $signed(sample_out), 0);
    check("rst_wr", wr, 0);
    check("rst_mask", active_mask, 0);
    check("rst_last_note", last_note, 0);
    reset = 1'b0;

    // Idle: wr period and silent output
    wait_wr("idle_wr1");
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!wr && cyc < 2000);
    check("wr_period", cyc, 1042);
    check("idle_sample", $signed(sample_out), 0);
    check("idle_mask", active_mask, 0);

    // Single make of Q
    send_byte(8'h15);
    check("q_mask", active_mask, 4'b0001);
    check("q_last_note", last_note, 8'h15);
    check("q_half_period", dut.g_voice[0].u_voice.hp_q, 95556);
    wait_wr("q_wr");
    check("q_sample", $signed(sample_out), 4095);

    // Extended break is ignored, plain break releases
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h15);
    check("ext_brk_mask", active_mask, 4'b0001);
    send_byte(8'hF0); send_byte(8'h15);
    check("brk_mask", active_mask, 4'b0000);
    wait_wr("brk_wr");
    check("brk_sample", $signed(sample_out), 0);
    send_byte(8'hE0); send_byte(8'h15);
    check("ext_make_mask", active_mask, 4'b0000);
    send_byte(8'h1C);
    check("unmapped_mask", active_mask, 4'b0000);

    // Typematic repeat keeps the running counter
    send_byte(8'h1D);
    repeat (30) tick();
    cnt_snap = dut.g_voice[0].u_voice.cnt_q;
    send_byte(8'h1D); send_byte(8'h1D);
    check("rep_mask", active_mask, 4'b0001);
    check("rep_cnt", dut.g_voice[0].u_voice.cnt_q, cnt_snap + 21'd4);
    send_byte(8'hF0); send_byte(8'h1D);
    check("rep_release", active_mask, 4'b0000);

    // Five makes: fifth steals voice 0
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
    check("fill_mask", active_mask, 4'b1111);
    check("fill_steal_ptr", dut.steal_ptr_q, 0);
    send_byte(8'h2C);
    check("steal_mask", active_mask, 4'b1111);
    check("steal_hp", dut.g_voice[0].u_voice.hp_q, 75843);
    check("steal_code", dut.g_voice[0].u_voice.code_q, 8'h2C);
    check("steal_ptr", dut.steal_ptr_q, 1);
    check("steal_last_note", last_note, 8'h2C);
    wait_wr("four_wr");
    check("four_sample", $signed(sample_out), 16380);
    send_byte(8'hF0); send_byte(8'h1D);
    send_byte(8'hF0); send_byte(8'h24);
    send_byte(8'hF0); send_byte(8'h2D);
    send_byte(8'hF0); send_byte(8'h2C);
    check("all_release", active_mask, 4'b0000);

    // Volume saturation with one voice sounding
    send_byte(8'h15);
    repeat (9) pulse_vol(1'b1, 1'b0);
    wait_wr("vmax_wr");
    check("vol_max_sample", $signed(sample_out), 8191);
    repeat (20) pulse_vol(1'b0, 1'b1);
    wait_wr("vmin_wr");
    check("vol_min_sample", $signed(sample_out), 0);
    pulse_vol(1'b1, 1'b0);
    wait_wr("vstep_wr");
    check("vol_step_sample", $signed(sample_out), 512);
    pulse_vol(1'b1, 1'b1);
    wait_wr("vboth_wr");
    check("vol_both_sample", $signed(sample_out), 512);

    // Reset mid-note silences at once
    reset = 1'b1;
    #1;
    check("midrst_sample", $signed(sample_out), 0);
    check("midrst_mask", active_mask, 0);
    tick();
    reset = 1'b0;

    // Level toggle boundary on the shortest note, then negative sample
    send_byte(8'h5B);
    check("rb_mask", active_mask, 4'b0001);
    repeat (50617) tick();
    check("rb_cnt_pre", dut.g_voice[0].u_voice.cnt_q, 50618);
    check("rb_level_pre", dut.g_voice[0].u_voice.level_q, 1);
    tick();
    check("rb_cnt_wrap", dut.g_voice[0].u_voice.cnt_q, 0);
    check("rb_level_post", dut.g_voice[0].u_voice.level_q, 0);
    wait_wr("neg_wr");
    check("neg_sample", $signed(sample_out), -4095);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
